// File: rtl/weight_loader.sv
// ============================================================================
// weight_loader
// ----------------------------------------------------------------------------
// Purpose:
//   Write-side counterpart of the synchronous weight ROM read path. Accepts a
//   stream of signed fixed-point weights (Q INT_WIDTH.FRAC_WIDTH) over a
//   valid/ready handshake and writes them to sequential addresses
//   0..NUM_WEIGHTS-1 of a single-port weight RAM. Raises done (level) once
//   the full image has been written.
//
// Ports:
//   clock          in   1        rising-edge clock
//   reset          in   1        asynchronous, active-low reset
//   start          in   1        begin a load (honoured in IDLE or DONE only)
//   in_valid       in   1        in_data holds a weight
//   in_ready       out  1        loader accepts in_data this cycle
//   in_data        in   WIDTH    signed weight [INT_WIDTH-1:-FRAC_WIDTH]
//   write_enable   out  1        RAM write strobe
//   write_address  out  ADDR_W   RAM write address
//   write_data     out  WIDTH    RAM write data
//   busy           out  1        high while loading
//   done           out  1        high once the image is loaded (level)
//   checksum       out  WIDTH    only with WEIGHT_LOADER_CHECKSUM_EN: sum
//                                modulo 2^WIDTH of all words accepted since
//                                the load began
//
// Configuration:
//   WEIGHT_LOADER_CHECKSUM_EN  when defined, adds the checksum port and its
//                              accumulator; otherwise neither exists.
// ============================================================================

module weight_loader #(
    parameter int INT_WIDTH   = 8,
    parameter int FRAC_WIDTH  = 8,
    parameter int NUM_WEIGHTS = 784,
    localparam int WIDTH      = INT_WIDTH + FRAC_WIDTH,
    localparam int ADDR_W     = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [WIDTH-1:0]  write_data,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [WIDTH-1:0]  checksum,
`endif
    output logic              busy,
    output logic              done
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Address of the final word of an image
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WEIGHTS - 1);

    logic [1:0]        state_q,   state_d;
    logic [ADDR_W-1:0] count_q,   count_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]  sum_q,     sum_d;
`endif

    logic loading;
    logic transfer;
    logic last_transfer;
    logic begin_load;

    // Ready is decoded from state alone so the upstream valid never has a
    // combinational path back to ready.
    assign loading       = (state_q == S_LOAD);
    assign transfer      = in_valid && loading;
    assign last_transfer = transfer && (count_q == LAST_ADDR);
    // start is only honoured outside LOAD; that also covers a start that
    // coincides with the final transfer, since that cycle is still in LOAD.
    assign begin_load    = start && !loading;

    // Next-state logic for the FSM and the word counter. The counter parks
    // on the last address after the final transfer instead of wrapping; it
    // is cleared again whenever a new load begins.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (begin_load) begin
                    state_d = S_LOAD;
                    count_d = '0;
                end
            end
            S_LOAD: begin
                if (last_transfer) begin
                    state_d = S_DONE;
                end else if (transfer) begin
                    count_d = count_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Write port: one registered write per accepted word, one cycle later.
    // Address and data hold their previous value when no write is issued.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (transfer) begin
            wr_en_d   = 1'b1;
            wr_addr_d = count_q;
            wr_data_d = in_data;
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    // Running sum tracks the write port so the final word is included in
    // the same cycle done first reads high.
    always_comb begin
        sum_d = sum_q;
        if (begin_load) begin
            sum_d = '0;
        end else if (transfer) begin
            sum_d = sum_q + in_data;
        end
    end
`endif

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

    assign in_ready      = loading;
    assign busy          = loading;
    assign done          = (state_q == S_DONE);
    assign write_enable  = wr_en_q;
    assign write_address = wr_addr_q;
    assign write_data    = wr_data_q;

endmodule
